// File: rtl/divider_32bits_sequential.sv
// Iterative restoring unsigned divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per cycle, start/done handshake, error fast path for /0 and overflow.
module divider_32bits_sequential #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH+1:0] trial;
    logic             qbit;
    logic [WIDTH-1:0] prem_next;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            prem_q      <= '0;
            shreg_q     <= '0;
            divisor_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            prem_q      <= prem_d;
            shreg_q     <= shreg_d;
            divisor_q   <= divisor_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state, iteration step and output register inputs
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        prem_d      = prem_q;
        shreg_d     = shreg_q;
        divisor_d   = divisor_q;
        cnt_d       = cnt_q;

        // A non-negative trial always fits in WIDTH bits, so either upper bit set means negative.
        trial     = {1'b0, prem_q, shreg_q[WIDTH-1]} - {2'b00, divisor_q};
        qbit      = ~(trial[WIDTH+1] | trial[WIDTH]);
        prem_next = qbit ? trial[WIDTH-1:0] : {prem_q[WIDTH-2:0], shreg_q[WIDTH-1]};

        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                    divisor_d   = divisor;
                    if (divisor == '0) begin
                        dbz_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dividend[WIDTH-1:0];
                        state_d     = DONE;
                    end else if (dividend[DW-1:WIDTH] >= divisor) begin
                        ovf_d      = 1'b1;
                        quotient_d = '1;
                        state_d    = DONE;
                    end else begin
                        busy_d  = 1'b1;
                        prem_d  = dividend[DW-1:WIDTH];
                        shreg_d = dividend[WIDTH-1:0];
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                prem_d  = prem_next;
                shreg_d = {shreg_q[WIDTH-2:0], qbit};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    quotient_d  = {shreg_q[WIDTH-2:0], qbit};
                    remainder_d = prem_next;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // Normal path arrives with done already high; error path raises it here.
                done_d  = ~done_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
